// File: rtl/mux_src_pkg.sv
// -----------------------------------------------------------------------------
// mux_src_pkg
//   Shared types and constants for the mux source loader: FSM state encoding,
//   slot count, slot index width and a wrapping slot-index increment helper.
// -----------------------------------------------------------------------------
package mux_src_pkg;

   localparam int NUM_SLOTS  = 4;
   localparam int SLOT_IDX_W = 2;

   typedef enum logic {
      ST_LOAD,
      ST_SCAN
   } state_t;

   typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

   // Modulo-4 increment; relies on the natural 2-bit wrap.
   function automatic slot_idx_t slot_inc(input slot_idx_t idx);
      return idx + slot_idx_t'(1);
   endfunction

endpackage

// File: rtl/mux_src_loader_if.sv
// -----------------------------------------------------------------------------
// mux_src_loader_if
//   Bundles the switch/button inputs and the selector-facing outputs of the
//   mux source loader.
//   Inputs to the loader : sw_data[W], btn_load, btn_clear, scan_en,
//                          sel_manual[2]
//   Outputs of the loader: X0..X3[W], Y[2], loaded[4], full,
//                          btn_level (debounced load-button level)
//   Modports: master = stimulus side, slave = loader side.
// -----------------------------------------------------------------------------
interface mux_src_loader_if
   import mux_src_pkg::*;
#(
   parameter int W = 2
);

   logic [W-1:0]            sw_data;
   logic                    btn_load;
   logic                    btn_clear;
   logic                    scan_en;
   logic [SLOT_IDX_W-1:0]   sel_manual;

   logic [W-1:0]            X0;
   logic [W-1:0]            X1;
   logic [W-1:0]            X2;
   logic [W-1:0]            X3;
   logic [SLOT_IDX_W-1:0]   Y;
   logic [NUM_SLOTS-1:0]    loaded;
   logic                    full;
   logic                    btn_level;

   modport master (
      output sw_data, btn_load, btn_clear, scan_en, sel_manual,
      input  X0, X1, X2, X3, Y, loaded, full, btn_level
   );

   modport slave (
      input  sw_data, btn_load, btn_clear, scan_en, sel_manual,
      output X0, X1, X2, X3, Y, loaded, full, btn_level
   );

endinterface

// File: rtl/mux_src_loader_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions the raw, bouncy load button into a single-cycle load pulse.
//   Chain: 2-flop synchronizer -> optional stability filter -> rising-edge
//   detect.
//   Configuration macro: MUX_SRC_DEBOUNCE_EN
//     defined   : a new synchronized level is accepted only after DEB_CYCLES
//                 consecutive equal samples; shorter glitches are dropped.
//     undefined : the filter is bypassed, the edge detect sees the
//                 synchronizer output directly (every bounce edge is a pulse).
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset (filter idles at level 0)
//     btn_i    in   raw asynchronous button
//     level_o  out  debounced (or synchronized, when bypassed) level
//     pulse_o  out  one-cycle pulse on each accepted rising edge of level_o
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic pulse_o
);

`ifdef MUX_SRC_DEBOUNCE_EN
   localparam bit FILTER_ON = 1'b1;
`else
   localparam bit FILTER_ON = 1'b0;
`endif

   // Zero stability length selects the bypass path below.
   localparam int unsigned STABLE_LEN = FILTER_ON ? DEB_CYCLES : 0;

   logic [1:0] sync_q;
   logic       level;
   logic       level_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

   generate
      if (STABLE_LEN >= 1) begin : g_filter
         localparam int STAB_W = $clog2(STABLE_LEN) + 1;
         localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_LEN - 1);

         logic [STAB_W-1:0] stab_cnt_q;
         logic              level_q;

         // Counts consecutive samples that differ from the accepted level;
         // any sample equal to the accepted level restarts the window.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stab_cnt_q <= '0;
               level_q    <= 1'b0;
            end else if (sync_q[1] != level_q) begin
               if (stab_cnt_q == STAB_LAST) begin
                  level_q    <= sync_q[1];
                  stab_cnt_q <= '0;
               end else begin
                  stab_cnt_q <= stab_cnt_q + 1'b1;
               end
            end else begin
               stab_cnt_q <= '0;
            end
         end

         assign level = level_q;
      end else begin : g_bypass
         assign level = sync_q[1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_prev_q <= 1'b0;
      end else begin
         level_prev_q <= level;
      end
   end

   // Decoded from registers only, so the pulse is clean within the cycle and
   // the slot write lands on the following edge.
   assign pulse_o = level & ~level_prev_q;
   assign level_o = level;

endmodule

// File: rtl/mux_src_loader.sv
// -----------------------------------------------------------------------------
// mux_src_loader
//   Source stage for a 4:1 two-bit selector. Captures four W-bit operands from
//   switches into slots X0..X3 using a debounced load button; once all four
//   slots are written it drives the select Y from an auto-scan divider or from
//   the manual select switches.
//   Configuration macro: MUX_SRC_DEBOUNCE_EN (consumed inside btn_debounce;
//   enables the DEB_CYCLES stability filter on the load button).
//   Ports:
//     clk   in      rising-edge clock
//     rst   in      asynchronous active-high reset
//     bus   slave   mux_src_loader_if: sw_data, btn_load, btn_clear, scan_en,
//                   sel_manual in; X0..X3, Y, loaded, full, btn_level out
//   Parameters: W (operand width), DEB_CYCLES (debounce window),
//               SCAN_DIV (clk cycles per Y step while scanning).
// -----------------------------------------------------------------------------
module mux_src_loader
   import mux_src_pkg::*;
#(
   parameter int W          = 2,
   parameter int DEB_CYCLES = 16,
   parameter int SCAN_DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   mux_src_loader_if.slave  bus
);

   localparam int              CNT_W     = $clog2(SCAN_DIV) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam slot_idx_t        SLOT_LAST = slot_idx_t'(NUM_SLOTS - 1);

   state_t               state_q;
   slot_idx_t            wr_ptr_q;
   slot_idx_t            y_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 full_q;
   logic [W-1:0]         slot_q   [NUM_SLOTS];
   logic                 loaded_q [NUM_SLOTS];

   logic                 ld_pulse;
   logic                 btn_level;
   logic                 load_fire_d;
   logic [NUM_SLOTS-1:0] slot_we_d;
   logic [NUM_SLOTS-1:0] loaded_vec;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.btn_load),
      .level_o (btn_level),
      .pulse_o (ld_pulse)
   );

   // A load only counts while filling, and a same-cycle clear discards it.
   assign load_fire_d = (state_q == ST_LOAD) && ld_pulse && !bus.btn_clear;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign slot_we_d[gi] = load_fire_d && (wr_ptr_q == slot_idx_t'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_q[gi]   <= '0;
               loaded_q[gi] <= 1'b0;
            end else if (bus.btn_clear) begin
               slot_q[gi]   <= '0;
               loaded_q[gi] <= 1'b0;
            end else if (slot_we_d[gi]) begin
               slot_q[gi]   <= bus.sw_data;
               loaded_q[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   always_comb begin
      loaded_vec = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         loaded_vec[i] = loaded_q[i];
      end
   end

   // Control FSM: write pointer, select register, scan divider, full flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         wr_ptr_q <= '0;
         y_q      <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
      end else if (bus.btn_clear) begin
         state_q  <= ST_LOAD;
         wr_ptr_q <= '0;
         y_q      <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               // While filling, Y shows the slot about to be written.
               if (ld_pulse) begin
                  if (wr_ptr_q == SLOT_LAST) begin
                     state_q  <= ST_SCAN;
                     full_q   <= 1'b1;
                     wr_ptr_q <= '0;
                     y_q      <= '0;
                     cnt_q    <= '0;
                  end else begin
                     wr_ptr_q <= slot_inc(wr_ptr_q);
                     y_q      <= slot_inc(wr_ptr_q);
                  end
               end else begin
                  y_q <= wr_ptr_q;
               end
            end
            ST_SCAN: begin
               if (bus.scan_en) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q <= '0;
                     y_q   <= slot_inc(y_q);
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  // Holding the divider at zero makes a re-enable start a
                  // full SCAN_DIV period from the current Y.
                  cnt_q <= '0;
                  y_q   <= bus.sel_manual;
               end
            end
            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

   assign bus.X0        = slot_q[0];
   assign bus.X1        = slot_q[1];
   assign bus.X2        = slot_q[2];
   assign bus.X3        = slot_q[3];
   assign bus.Y         = y_q;
   assign bus.loaded    = loaded_vec;
   assign bus.full      = full_q;
   assign bus.btn_level = btn_level;

endmodule

// File: tb/tb_mux_src_loader.sv
// -----------------------------------------------------------------------------
// tb_mux_src_loader
//   Directed, table-driven bench for mux_src_loader (W=2, DEB_CYCLES=16,
//   SCAN_DIV=4). Adapts its load latency and glitch/bounce expectations to
//   whether MUX_SRC_DEBOUNCE_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_src_loader;

   localparam int DEB = 16;

`ifdef MUX_SRC_DEBOUNCE_EN
   localparam int LAT    = 2 + DEB + 1;
   localparam int HOLD   = 20;
   localparam int SETTLE = DEB + 6;
`else
   localparam int LAT    = 3;
   localparam int HOLD   = 4;
   localparam int SETTLE = 5;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   mux_src_loader_if #(.W(2)) bus ();

   mux_src_loader #(
      .W          (2),
      .DEB_CYCLES (DEB),
      .SCAN_DIV   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          press;
      logic [1:0]  data;
      logic        scan_en;
      logic [1:0]  sel;
      int          cycles;
      logic [1:0]  x0, x1, x2, x3;
      logic [1:0]  y;
      logic [3:0]  loaded;
      logic        full;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag,
                            input logic [1:0] x0, input logic [1:0] x1,
                            input logic [1:0] x2, input logic [1:0] x3,
                            input logic [1:0] y, input logic [3:0] ld, input logic fl);
      check({tag, ".X0"}, 32'(bus.X0), 32'(x0));
      check({tag, ".X1"}, 32'(bus.X1), 32'(x1));
      check({tag, ".X2"}, 32'(bus.X2), 32'(x2));
      check({tag, ".X3"}, 32'(bus.X3), 32'(x3));
      check({tag, ".Y"}, 32'(bus.Y), 32'(y));
      check({tag, ".loaded"}, 32'(bus.loaded), 32'(ld));
      check({tag, ".full"}, 32'(bus.full), 32'(fl));
   endtask

   // Clean press starting at a negedge: hold HOLD cycles, release, settle.
   task automatic press(input logic [1:0] d);
      bus.sw_data  = d;
      bus.btn_load = 1'b1;
      repeat (HOLD) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (SETTLE) @(negedge clk);
   endtask

   // Press that also checks the write lands exactly LAT edges after the rise.
   task automatic press_timed(input logic [1:0] d, input int slot);
      logic [3:0] old;
      old = bus.loaded;
      bus.sw_data  = d;
      bus.btn_load = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == LAT - 1) check("lat_early.loaded", 32'(bus.loaded), 32'(old));
         if (k == LAT)     check("lat_edge.loaded", 32'(bus.loaded), 32'(old | (4'b1 << slot)));
      end
      repeat (HOLD - LAT) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (SETTLE) @(negedge clk);
   endtask

   initial begin
      logic [1:0] y_exp;

      // press data scan sel cyc  X0 X1 X2 X3  Y  loaded  full
      tbl[0] = '{1'b1, 2'd1, 1'b0, 2'd0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0001, 1'b0};
      tbl[1] = '{1'b1, 2'd2, 1'b0, 2'd0, 0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 4'b0011, 1'b0};
      tbl[2] = '{1'b1, 2'd3, 1'b0, 2'd0, 0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 4'b0111, 1'b0};
      tbl[3] = '{1'b1, 2'd0, 1'b0, 2'd0, 0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 4'b1111, 1'b1};
      tbl[4] = '{1'b0, 2'd0, 1'b0, 2'd2, 1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 4'b1111, 1'b1};
      tbl[5] = '{1'b0, 2'd0, 1'b0, 2'd1, 2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 4'b1111, 1'b1};
      tbl[6] = '{1'b0, 2'd0, 1'b0, 2'd0, 1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 4'b1111, 1'b1};

      bus.sw_data    = '0;
      bus.btn_load   = 1'b0;
      bus.btn_clear  = 1'b0;
      bus.scan_en    = 1'b0;
      bus.sel_manual = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_all("reset", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Four loads then manual select, table driven
      for (int i = 0; i < 7; i++) begin
         bus.scan_en    = tbl[i].scan_en;
         bus.sel_manual = tbl[i].sel;
         if (tbl[i].press) press(tbl[i].data);
         else repeat (tbl[i].cycles) @(negedge clk);
         check_all($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3,
                   tbl[i].y, tbl[i].loaded, tbl[i].full);
      end

      // Loads are ignored while scanning
      press(2'd3);
      check_all("scan_noload", 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 4'b1111, 1'b1);

      // Auto-scan: one Y step every 4 edges, wrapping after 3
      bus.scan_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         y_exp = 2'((k / 4) % 4);
         check($sformatf("scan_k%0d.Y", k), 32'(bus.Y), 32'(y_exp));
      end

      // Manual select with one-cycle latency, then fresh scan period
      bus.scan_en    = 1'b0;
      bus.sel_manual = 2'd2;
      check("manual_pre.Y", 32'(bus.Y), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("manual_post.Y", 32'(bus.Y), 32'd2);
      bus.scan_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("rescan_k%0d.Y", k), 32'(bus.Y), (k == 4) ? 32'd3 : 32'd2);
      end

      // Asynchronous reset mid-cycle while scanning with Y=3
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all("async_rst", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0);
      @(negedge clk);
      rst         = 1'b0;
      bus.scan_en = 1'b0;
      repeat (2) @(negedge clk);

      // LOAD resumes, with exact load latency
      press_timed(2'd2, 0);
      check_all("resume", 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0001, 1'b0);
      press(2'd1);
      check_all("wr2", 2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 4'b0011, 1'b0);

      // Clear and load pulse in the same cycle with wr_ptr=2
      bus.sw_data  = 2'd3;
      bus.btn_load = 1'b1;
      repeat (LAT - 1) begin
         @(posedge clk);
         @(negedge clk);
      end
      bus.btn_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.btn_clear = 1'b0;
      check_all("clear_beats_load", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 1'b0);
      repeat (HOLD - LAT) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (SETTLE) @(negedge clk);
      check("clear_hold.loaded", 32'(bus.loaded), 32'd0);

      press(2'd3);
      check_all("after_clear", 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0001, 1'b0);

`ifdef MUX_SRC_DEBOUNCE_EN
      // Short glitch is filtered out
      bus.sw_data  = 2'd2;
      bus.btn_load = 1'b1;
      repeat (5) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (40) @(negedge clk);
      check_all("glitch", 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0001, 1'b0);
`else
      // Without the filter each bounce edge is a separate load
      bus.sw_data  = 2'd2;
      bus.btn_load = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (3) @(negedge clk);
      bus.btn_load = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (6) @(negedge clk);
      check_all("bounce", 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 4'b0111, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
